// File: rtl/cluster_merge_n.sv
// Merges two presorted halves of cluster slots into one ascending list using a
// registered Batcher odd-even merge, keeping the lowest MXOUT slots and tracking overflow.
module cluster_merge_n #(
    parameter int MXIN      = 16,
    parameter int MXOUT     = 8,
    parameter int MXADRBITS = 11,
    parameter int MXCNTBITS = 3
) (
    input  logic                       clock4x,
    input  logic                       reset_n,
    input  logic                       valid_in,
    input  logic [MXIN*MXADRBITS-1:0]  adr_in,
    input  logic [MXIN*MXCNTBITS-1:0]  cnt_in,
    input  logic [MXIN-1:0]            vpfs,
    input  logic                       clear_cnt,
    output logic                       valid_out,
    output logic [MXOUT*MXADRBITS-1:0] adr_out,
    output logic [MXOUT*MXCNTBITS-1:0] cnt_out,
    output logic [MXOUT-1:0]           vpf_out,
    output logic                       overflow,
    output logic [15:0]                overflow_cnt
);

    localparam int LAT = $clog2(MXIN);
    localparam int PCW = $clog2(MXIN + 1);

    logic [MXADRBITS-1:0] r_adr [LAT][MXIN];
    logic [MXCNTBITS-1:0] r_cnt [LAT][MXIN];
    logic [MXIN-1:0]      r_vpf [LAT];
    logic [LAT-1:0]       r_valid;
    logic [LAT-1:0]       r_ovf;
    logic [15:0]          r_ovf_cnt;

    logic [MXADRBITS-1:0] w_src_adr [LAT][MXIN];
    logic [MXCNTBITS-1:0] w_src_cnt [LAT][MXIN];
    logic [MXIN-1:0]      w_src_vpf [LAT];
    logic [MXADRBITS-1:0] w_nxt_adr [LAT][MXIN];
    logic [MXCNTBITS-1:0] w_nxt_cnt [LAT][MXIN];
    logic [MXIN-1:0]      w_nxt_vpf [LAT];
    logic [PCW-1:0]       w_popcnt;
    logic                 w_ovf;

    // Invalid slots carry the largest possible key so they always settle at the top.
    function automatic logic key_gt(input logic va, input logic [MXADRBITS-1:0] aa,
                                    input logic vb, input logic [MXADRBITS-1:0] ab);
        return {~va, aa} > {~vb, ab};
    endfunction

    always_comb begin
        for (int i = 0; i < MXIN; i++) begin
            w_src_vpf[0][i] = vpfs[i];
            w_src_adr[0][i] = vpfs[i] ? adr_in[i*MXADRBITS +: MXADRBITS] : '1;
            w_src_cnt[0][i] = vpfs[i] ? cnt_in[i*MXCNTBITS +: MXCNTBITS] : '0;
        end
        for (int l = 1; l < LAT; l++) begin
            w_src_vpf[l] = r_vpf[l-1];
            for (int i = 0; i < MXIN; i++) begin
                w_src_adr[l][i] = r_adr[l-1][i];
                w_src_cnt[l][i] = r_cnt[l-1][i];
            end
        end
    end

    // Layer l compares slots k apart (k = MXIN/2 >> l); later layers skip the outer k slots.
    always_comb begin
        for (int l = 0; l < LAT; l++) begin
            w_nxt_vpf[l] = w_src_vpf[l];
            for (int i = 0; i < MXIN; i++) begin
                int  k;
                int  o;
                int  p;
                logic lower;
                logic swap;
                k = (MXIN / 2) >> l;
                o = (l == 0) ? 0 : k;
                p = i;
                lower = 1'b0;
                swap = 1'b0;
                w_nxt_adr[l][i] = w_src_adr[l][i];
                w_nxt_cnt[l][i] = w_src_cnt[l][i];
                if (i >= o && i < MXIN - o) begin
                    lower = ((i - o) % (2 * k)) < k;
                    p = lower ? i + k : i - k;
                    swap = lower ? key_gt(w_src_vpf[l][i], w_src_adr[l][i], w_src_vpf[l][p], w_src_adr[l][p])
                                 : key_gt(w_src_vpf[l][p], w_src_adr[l][p], w_src_vpf[l][i], w_src_adr[l][i]);
                    if (swap) begin
                        w_nxt_adr[l][i] = w_src_adr[l][p];
                        w_nxt_cnt[l][i] = w_src_cnt[l][p];
                        w_nxt_vpf[l][i] = w_src_vpf[l][p];
                    end
                end
            end
        end
    end

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < MXIN; i++) begin
            w_popcnt = w_popcnt + PCW'(vpfs[i]);
        end
        w_ovf = valid_in && (w_popcnt > PCW'(MXOUT));
    end

    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            for (int l = 0; l < LAT; l++) begin
                r_vpf[l] <= '0;
                for (int i = 0; i < MXIN; i++) begin
                    r_adr[l][i] <= '1;
                    r_cnt[l][i] <= '0;
                end
            end
            r_valid <= '0;
            r_ovf   <= '0;
        end else begin
            for (int l = 0; l < LAT; l++) begin
                r_vpf[l] <= w_nxt_vpf[l];
                for (int i = 0; i < MXIN; i++) begin
                    r_adr[l][i] <= w_nxt_adr[l][i];
                    r_cnt[l][i] <= w_nxt_cnt[l][i];
                end
            end
            r_valid <= {r_valid[LAT-2:0], valid_in};
            r_ovf   <= {r_ovf[LAT-2:0], w_ovf};
        end
    end

    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf_cnt <= '0;
        end else if (clear_cnt) begin
            r_ovf_cnt <= '0;
        end else if (r_valid[LAT-1] && r_ovf[LAT-1] && r_ovf_cnt != 16'hFFFF) begin
            r_ovf_cnt <= r_ovf_cnt + 16'd1;
        end
    end

    always_comb begin
        for (int j = 0; j < MXOUT; j++) begin
            adr_out[j*MXADRBITS +: MXADRBITS] = r_adr[LAT-1][j];
            cnt_out[j*MXCNTBITS +: MXCNTBITS] = r_cnt[LAT-1][j];
            vpf_out[j]                        = r_vpf[LAT-1][j];
        end
    end

    assign valid_out    = r_valid[LAT-1];
    assign overflow     = r_ovf[LAT-1];
    assign overflow_cnt = r_ovf_cnt;

endmodule

// File: doc/cluster_merge_n.md
CLUSTER_MERGE_N -- requirements
Module: cluster_merge_n

Interface
REQ-001 SHALL have parameter MXIN, default 16, meaning total input cluster slots; power of 2, 4..64.
REQ-002 SHALL have parameter MXOUT, default 8, meaning output slots kept; 1..MXIN.
REQ-003 SHALL have parameter MXADRBITS, default 11, meaning cluster address width.
REQ-004 SHALL have parameter MXCNTBITS, default 3, meaning cluster size-count width.
REQ-005 SHALL have port clock4x, input, 1, meaning the single clock. All logic runs in this one domain.
REQ-006 SHALL have port reset_n, input, 1, meaning reset. It is asynchronous and active-low.
REQ-007 SHALL have port valid_in, input, 1, meaning the input frame is valid this cycle.
REQ-008 SHALL have port adr_in, input, MXIN*MXADRBITS, meaning the flat slot addresses; slot i occupies bits [i*MXADRBITS +: MXADRBITS].
REQ-009 SHALL have port cnt_in, input, MXIN*MXCNTBITS, meaning the flat slot counts, packed the same way as adr_in.
REQ-010 SHALL have port vpfs, input, MXIN, meaning the per-slot valid-pattern flag.
REQ-011 SHALL have port clear_cnt, input, 1, meaning synchronous clear of overflow_cnt.
REQ-012 SHALL have port valid_out, output, 1, meaning the output frame is valid.
REQ-013 SHALL have port adr_out, output, MXOUT*MXADRBITS, meaning the sorted addresses, smallest in slot 0.
REQ-014 SHALL have port cnt_out, output, MXOUT*MXCNTBITS, meaning the counts paired with adr_out.
REQ-015 SHALL have port vpf_out, output, MXOUT, meaning the per-slot valid flag of the output.
REQ-016 SHALL have port overflow, output, 1, meaning the frame held more than MXOUT valid clusters.
REQ-017 SHALL have port overflow_cnt, output, 16, meaning the saturating count of overflow frames.

Function
REQ-018 SHALL treat the input as two presorted halves: slots 0..MXIN/2-1 and MXIN/2..MXIN-1, each ascending by key after masking. Behaviour is undefined otherwise.
REQ-019 SHALL, at entry, mask each slot with vpfs[i]=0 to adr all-ones, cnt 0, vpf 0.
REQ-020 SHALL sort on the key {~vpf, adr}, so invalid slots always sort after valid ones.
REQ-021 SHALL merge the two halves using Batcher odd-even merge of log2(MXIN) comparator layers, carrying adr, cnt and vpf as one record.
REQ-022 SHALL have each comparator keep order when key(lower) <= key(upper), and swap otherwise.
REQ-023 SHALL register every comparator layer, giving a fixed latency LAT = log2(MXIN) cycles from valid_in to valid_out (4 for the default).
REQ-024 SHALL run the pipeline with no stall: a new frame is accepted every cycle and valid_in is delayed LAT cycles to form valid_out.
REQ-025 SHALL drive outputs from the lowest MXOUT merged slots. Data is don't-care while valid_out=0.
REQ-026 SHALL compute overflow as popcount(vpfs) > MXOUT at entry, pipelined so it aligns with valid_out, and gated by valid_in.
REQ-027 SHALL increment overflow_cnt by 1 on each cycle where valid_out=1 and overflow=1.
REQ-028 SHALL saturate overflow_cnt at 0xFFFF with no wrap.
REQ-029 SHALL give clear_cnt priority over increment, so the counter reads 0 the next cycle.
REQ-030 SHALL, when addresses are equal among valid slots, order those slots per REQ-022. The scoreboard matches adr_out exactly and matches {adr,cnt} as a multiset within each equal-address group.

Reset
REQ-031 SHALL, while reset_n=0, asynchronously force every pipeline record to adr all-ones, cnt 0, vpf 0.
REQ-032 SHALL, while reset_n=0, asynchronously force valid_out=0, overflow=0 and overflow_cnt=0.
REQ-033 SHALL, on reset assertion mid-flight, discard all in-flight frames; the first valid_out after release corresponds to a valid_in sampled after release.

Verification
REQ-034 SHALL cover: reset release with valid_in=0 -> valid_out=0, adr_out all 0x7FF, cnt_out 0, vpf_out 0, overflow_cnt 0.
REQ-035 SHALL cover: MXIN=16, lower half valid adr {3,20,100}, upper half valid adr {5,6,200}, rest vpf=0 -> after 4 cycles adr_out={3,5,6,20,100,200,7FF,7FF}, vpf_out=0x3F, overflow=0.
REQ-036 SHALL cover: all 16 vpfs=1, adr 0..15 interleaved across the halves -> adr_out=0..7, overflow=1, overflow_cnt increments by 1.
REQ-037 SHALL cover: 50 back-to-back random presorted frames -> each output matches the reference model exactly LAT cycles later, with no gaps.
REQ-038 SHALL cover: overflow_cnt preloaded to 0xFFFF by 65535 overflow frames, then one more -> count stays 0xFFFF; clear_cnt coincident with an overflow frame -> 0.
REQ-039 SHALL cover: reset_n pulsed low while 3 frames are in flight -> no valid_out from those frames; outputs at reset values immediately.
